pos_cell_access_ctrl: RTL and testbench

Sequencer and arbiter for one single-port cell position memory (`cell_X_Y_Z`, 2-cycle read latency, address 0 = particle count, addresses 1..N = `{posz, posy, posx}`). It serves two requesters:
- the force-evaluation side, which issues one start pulse and receives the cell's full particle stream;
- the motion-update side, which writes back positions and the new count word one at a time using a req/grant handshake.

One instance sits between each cell memory and its `Pos_Cache` consumers.

---
 rtl/pos_cell_access_ctrl_pkg.sv | 20 ++
 rtl/pos_cell_access_ctrl_if.sv | 44 ++++
 rtl/pos_cell_access_ctrl_rd_valid_pipe.sv | 31 +++
 rtl/pos_cell_access_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pos_cell_access_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pos_cell_access_ctrl_pkg.sv
// Shared definitions for the cell position memory access controllers.
// Every 3D cell instance imports this package.
package pos_cell_access_ctrl_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CNT_ISSUE = 3'd1,
    CNT_WAIT  = 3'd2,
    STREAM    = 3'd3,
    DRAIN     = 3'd4
  } state_e;

  // Cycles from address/rden presentation to valid ram_q
  localparam int RAM_RD_LATENCY = 2;

  // Address of the particle count word
  localparam int CNT_ADDR = 0;

endpackage

// File: rtl/pos_cell_access_ctrl_if.sv
// Bundle of the read-stream, write-back and memory-side signals of one
// cell position memory controller. The slave view belongs to the controller.
interface pos_cell_access_ctrl_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
) ();

  // Force-evaluation (read stream) side
  logic                  rd_start;
  logic                  rd_busy;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic                  rd_empty;

  // Motion-update (write-back) side
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_grant;

  // Sticky error flag
  logic                  err;

  // Memory side
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  ram_rden;
  logic                  ram_wren;
  logic [DATA_WIDTH-1:0] ram_q;

  modport slave (
    input  rd_start, wr_req, wr_addr, wr_data, ram_q,
    output rd_busy, rd_valid, rd_data, rd_last, rd_empty, wr_grant, err,
           ram_address, ram_data, ram_rden, ram_wren
  );

  modport master (
    output rd_start, wr_req, wr_addr, wr_data, ram_q,
    input  rd_busy, rd_valid, rd_data, rd_last, rd_empty, wr_grant, err,
           ram_address, ram_data, ram_rden, ram_wren
  );

endinterface

// File: rtl/pos_cell_access_ctrl_rd_valid_pipe.sv
// Delay line that follows particle reads through the memory read latency,
// so that {valid, last} line up with the word appearing on ram_q.
module pos_cell_access_ctrl_rd_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic rst_n,
  input  logic valid_i,
  input  logic last_i,
  output logic valid_o,
  output logic last_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] last_q;

  // Shift the issued-read flags one stage per cycle; reset flushes them.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      valid_q <= {DEPTH{1'b0}};
      last_q  <= {DEPTH{1'b0}};
    end else begin
      valid_q <= {valid_q[DEPTH-2:0], valid_i};
      last_q  <= {last_q[DEPTH-2:0], last_i};
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign last_o  = last_q[DEPTH-1];

endmodule

// File: rtl/pos_cell_access_ctrl.sv
// Sequencer and arbiter for one single-port cell position memory.
// Address 0 holds the particle count; 1..N hold {posz, posy, posx}.
// Writes are accepted only while idle; a read request streams the whole cell.
module pos_cell_access_ctrl
  import pos_cell_access_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input logic                  clock,
  input logic                  rst_n,
  pos_cell_access_ctrl_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] CNT_ADDR_W = ADDR_WIDTH'(CNT_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR  = {ADDR_WIDTH{1'b0}};
  localparam logic [1:0]            WAIT_LAST  = 2'(RAM_RD_LATENCY - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] ram_address_q;
  logic [DATA_WIDTH-1:0] ram_data_q;
  logic                  ram_rden_q;
  logic                  ram_wren_q;
  logic                  iss_valid_q;
  logic                  iss_last_q;
  logic                  rd_pending_q;
  logic                  err_q;
  logic [1:0]            wait_q;

  logic                  busy;
  logic                  grant;
  logic                  wr_in_range;
  logic                  rd_go;
  logic                  cnt_ready;
  logic [ADDR_WIDTH-1:0] cnt_raw;
  logic [ADDR_WIDTH-1:0] cnt_d;
  logic                  pipe_valid;
  logic                  pipe_last;

  assign busy        = (state_q != IDLE);
  // Writes win over reads and are only taken while idle.
  assign grant       = rst_n && (state_q == IDLE) && bus.wr_req;
  assign wr_in_range = (bus.wr_addr <= LAST_ADDR);
  assign rd_go       = (state_q == IDLE) && (bus.rd_start || rd_pending_q) && !bus.wr_req;
  // The count word is on ram_q in the last CNT_WAIT cycle.
  assign cnt_ready   = (state_q == CNT_WAIT) && (wait_q == WAIT_LAST);
  assign cnt_raw     = bus.ram_q[ADDR_WIDTH-1:0];
  // A corrupt count larger than the cell must not run past the memory.
  assign cnt_d       = (cnt_raw > LAST_ADDR) ? LAST_ADDR : cnt_raw;

  // Sequencer: arbitration, count fetch, address generation and memory controls.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= ZERO_ADDR;
      ram_address_q <= ZERO_ADDR;
      ram_data_q    <= {DATA_WIDTH{1'b0}};
      ram_rden_q    <= 1'b0;
      ram_wren_q    <= 1'b0;
      iss_valid_q   <= 1'b0;
      iss_last_q    <= 1'b0;
      rd_pending_q  <= 1'b0;
      err_q         <= 1'b0;
      wait_q        <= 2'd0;
    end else begin
      ram_rden_q  <= 1'b0;
      ram_wren_q  <= 1'b0;
      iss_valid_q <= 1'b0;
      iss_last_q  <= 1'b0;

      // A read request that cannot start now is held once; a second is dropped.
      if (rd_go) begin
        rd_pending_q <= 1'b0;
        if (bus.rd_start && rd_pending_q) begin
          err_q <= 1'b1;
        end
      end else if (bus.rd_start) begin
        if (!rd_pending_q) begin
          rd_pending_q <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end

      // Out-of-range writes are granted so the requester does not hang.
      if (grant && !wr_in_range) begin
        err_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (grant) begin
            ram_address_q <= bus.wr_addr;
            ram_data_q    <= bus.wr_data;
            ram_wren_q    <= wr_in_range;
          end else if (rd_go) begin
            ram_address_q <= CNT_ADDR_W;
            ram_rden_q    <= 1'b1;
            state_q       <= CNT_ISSUE;
          end
        end
        CNT_ISSUE: begin
          wait_q  <= 2'd0;
          state_q <= CNT_WAIT;
        end
        CNT_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            cnt_q <= cnt_d;
            if (cnt_d == ZERO_ADDR) begin
              state_q <= IDLE;
            end else begin
              ram_address_q <= ONE_ADDR;
              ram_rden_q    <= 1'b1;
              iss_valid_q   <= 1'b1;
              iss_last_q    <= (cnt_d == ONE_ADDR);
              state_q       <= STREAM;
            end
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
        STREAM: begin
          if (ram_address_q == cnt_q) begin
            wait_q  <= 2'd0;
            state_q <= DRAIN;
          end else begin
            ram_address_q <= ram_address_q + ONE_ADDR;
            ram_rden_q    <= 1'b1;
            iss_valid_q   <= 1'b1;
            iss_last_q    <= ((ram_address_q + ONE_ADDR) == cnt_q);
          end
        end
        DRAIN: begin
          if (wait_q == WAIT_LAST) begin
            state_q <= IDLE;
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  pos_cell_access_ctrl_rd_valid_pipe #(
    .DEPTH (RAM_RD_LATENCY)
  ) u_rd_valid_pipe (
    .clock   (clock),
    .rst_n   (rst_n),
    .valid_i (iss_valid_q),
    .last_i  (iss_last_q),
    .valid_o (pipe_valid),
    .last_o  (pipe_last)
  );

  assign bus.rd_busy     = busy;
  assign bus.rd_valid    = pipe_valid;
  assign bus.rd_last     = pipe_last;
  assign bus.rd_data     = bus.ram_q;
  // The count read-back is only meaningful in the cycle it is on ram_q.
  assign bus.rd_empty    = rst_n && cnt_ready && (cnt_d == ZERO_ADDR);
  assign bus.wr_grant    = grant;
  assign bus.err         = err_q;
  assign bus.ram_address = ram_address_q;
  assign bus.ram_data    = ram_data_q;
  assign bus.ram_rden    = ram_rden_q;
  assign bus.ram_wren    = ram_wren_q;

endmodule

// File: tb/tb_pos_cell_access_ctrl.sv
// Bench for pos_cell_access_ctrl: a 2-cycle-latency memory model plus a
// reference image of the cell contents and the stream timing rules.
module tb_pos_cell_access_ctrl;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic clock;
  logic rst_n;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] mem     [0:255];
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] q1;

  pos_cell_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  pos_cell_access_ctrl #(
    .DATA_WIDTH   (DW),
    .PARTICLE_NUM (PN),
    .ADDR_WIDTH   (AW)
  ) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Memory model: write on wren, read data appears two cycles after rden.
  always @(posedge clock) begin
    if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
    q1        <= bus.ram_rden ? mem[bus.ram_address] : '0;
    bus.ram_q <= q1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Count word with random upper bits; only the low address bits hold the count.
  task automatic load_cell(input int cnt, input int nwords);
    mem[0]     = {$urandom, $urandom, 24'($urandom), 8'(cnt)};
    ref_mem[0] = mem[0];
    for (int i = 1; i <= nwords; i++) begin
      mem[i]     = rand_word();
      ref_mem[i] = mem[i];
    end
  endtask

  task automatic pulse_rd_start(output int t);
    @(posedge clock); #1;
    bus.rd_start = 1'b1;
    t = cyc;
    @(posedge clock); #1;
    bus.rd_start = 1'b0;
  endtask

  // Checks a whole stream whose request was sampled in cycle t0 with n beats expected.
  task automatic run_stream(input string name, input int t0, input int n);
    int         c_end;
    logic [3:0] got;
    logic [3:0] want;
    c_end = (n == 0) ? t0 + 4 : t0 + 6 + n;
    for (int c = t0 + 1; c <= c_end; c++) begin
      do @(negedge clock); while (cyc < c);
      want[3] = (n > 0) && (c >= t0 + 6) && (c <= t0 + 5 + n);
      want[2] = (n > 0) && (c == t0 + 5 + n);
      want[1] = (n == 0) ? (c <= t0 + 3) : (c <= t0 + 5 + n);
      want[0] = (n == 0) && (c == t0 + 3);
      got = {bus.rd_valid, bus.rd_last, bus.rd_busy, bus.rd_empty};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s flags at t+%0d (valid,last,busy,empty): got %b expected %b",
                 name, c - t0, got, want);
      end
      if (want[3]) begin
        checks++;
        if (bus.rd_data !== ref_mem[c - t0 - 5]) begin
          errors++;
          $display("FAIL %s data beat %0d: got %h expected %h",
                   name, c - t0 - 5, bus.rd_data, ref_mem[c - t0 - 5]);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [DW+AW+7:0] got;
    rst_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    got = {bus.rd_busy, bus.rd_valid, bus.rd_last, bus.rd_empty, bus.wr_grant, bus.err,
           bus.ram_rden, bus.ram_wren, bus.ram_address, bus.ram_data};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_during outputs: got %h expected 0", got);
    end
    rst_n = 1'b1;
    @(negedge clock);
    got = {bus.rd_busy, bus.rd_valid, bus.rd_last, bus.rd_empty, bus.wr_grant, bus.err,
           bus.ram_rden, bus.ram_wren, bus.ram_address, bus.ram_data};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_after outputs: got %h expected 0", got);
    end
  endtask

  task automatic test_basic(input string name, input int n);
    int t;
    load_cell(n, n);
    pulse_rd_start(t);
    run_stream(name, t, n);
  endtask

  task automatic test_empty();
    int t;
    load_cell(0, 4);
    pulse_rd_start(t);
    run_stream("empty", t, 0);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0]    addrs [$];
    logic [DW-1:0]    datas [$];
    logic [DW+AW:0]   got;
    logic [DW+AW:0]   want;
    int               n;
    int               t;
    n = $urandom_range(6, 2);
    load_cell(0, 8);
    addrs.push_back(8'd0);
    datas.push_back({$urandom, $urandom, 24'($urandom), 8'(n)});
    for (int i = 1; i <= n; i++) begin
      addrs.push_back(8'(i));
      datas.push_back(rand_word());
    end
    for (int i = 0; i < addrs.size(); i++) begin
      @(posedge clock); #1;
      bus.wr_req  = 1'b1;
      bus.wr_addr = addrs[i];
      bus.wr_data = datas[i];
      @(negedge clock);
      checks++;
      if (bus.wr_grant !== 1'b1) begin
        errors++;
        $display("FAIL b2b grant %0d: got %b expected 1", i, bus.wr_grant);
      end
      if (i > 0) begin
        got  = {bus.ram_wren, bus.ram_address, bus.ram_data};
        want = {1'b1, addrs[i-1], datas[i-1]};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL b2b ram write %0d: got %h expected %h", i - 1, got, want);
        end
      end
      ref_mem[addrs[i]] = datas[i];
    end
    @(posedge clock); #1;
    bus.wr_req = 1'b0;
    @(negedge clock);
    got  = {bus.ram_wren, bus.ram_address, bus.ram_data};
    want = {1'b1, addrs[addrs.size()-1], datas[addrs.size()-1]};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL b2b ram write last: got %h expected %h", got, want);
    end
    @(negedge clock);
    checks++;
    if (bus.ram_wren !== 1'b0) begin
      errors++;
      $display("FAIL b2b wren after: got %b expected 0", bus.ram_wren);
    end
    pulse_rd_start(t);
    run_stream("b2b_stream", t, n);
  endtask

  task automatic test_tie();
    logic [DW+AW:0] got;
    int             n;
    int             t;
    n = $urandom_range(6, 3);
    load_cell(n, n);
    @(posedge clock); #1;
    bus.wr_req   = 1'b1;
    bus.wr_addr  = 8'd3;
    bus.wr_data  = 96'hABC;
    bus.rd_start = 1'b1;
    t = cyc;
    @(negedge clock);
    checks++;
    if ({bus.wr_grant, bus.rd_busy} !== 2'b10) begin
      errors++;
      $display("FAIL tie grant/busy: got %b expected 10", {bus.wr_grant, bus.rd_busy});
    end
    ref_mem[3] = 96'hABC;
    @(posedge clock); #1;
    bus.wr_req   = 1'b0;
    bus.rd_start = 1'b0;
    @(negedge clock);
    got = {bus.ram_wren, bus.ram_address, bus.ram_data};
    checks++;
    if (got !== {1'b1, 8'd3, 96'hABC} || bus.rd_busy !== 1'b0) begin
      errors++;
      $display("FAIL tie write then idle: got %h busy %b expected %h busy 0",
               got, bus.rd_busy, {1'b1, 8'd3, 96'hABC});
    end
    run_stream("tie_stream", t + 1, n);
  endtask

  task automatic test_overflow();
    int n;
    int t;
    n = $urandom_range(6, 3);
    load_cell(n, n);
    pulse_rd_start(t);
    fork
      run_stream("ovf_first", t, n);
      begin
        while (cyc < t + 2) begin
          @(posedge clock); #1;
        end
        bus.rd_start = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        checks++;
        if (bus.err !== 1'b0) begin
          errors++;
          $display("FAIL ovf err after first: got %b expected 0", bus.err);
        end
        @(posedge clock); #1;
        @(posedge clock); #1;
        bus.rd_start = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.err !== 1'b1) begin
          errors++;
          $display("FAIL ovf err after third: got %b expected 1", bus.err);
        end
      end
    join
    run_stream("ovf_pended", t + 6 + n, n);
  endtask

  task automatic test_clamp_range();
    int t;
    rst_n = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL clamp err cleared: got %b expected 0", bus.err);
    end
    load_cell(250, PN - 1);
    pulse_rd_start(t);
    run_stream("clamp", t, PN - 1);
    @(posedge clock); #1;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 8'd230;
    bus.wr_data = rand_word();
    @(negedge clock);
    checks++;
    if (bus.wr_grant !== 1'b1) begin
      errors++;
      $display("FAIL range grant: got %b expected 1", bus.wr_grant);
    end
    @(posedge clock); #1;
    bus.wr_req = 1'b0;
    @(negedge clock);
    checks++;
    if ({bus.ram_wren, bus.err} !== 2'b01) begin
      errors++;
      $display("FAIL range wren/err: got %b expected 01", {bus.ram_wren, bus.err});
    end
  endtask

  task automatic test_reset_mid();
    logic [DW+AW+7:0] got;
    int               t;
    load_cell(8, 8);
    pulse_rd_start(t);
    repeat (8) @(negedge clock);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== ref_mem[3]) begin
      errors++;
      $display("FAIL rstmid third beat: valid %b data %h expected 1 %h",
               bus.rd_valid, bus.rd_data, ref_mem[3]);
    end
    rst_n = 1'b0;
    @(negedge clock);
    got = {bus.rd_busy, bus.rd_valid, bus.rd_last, bus.rd_empty, bus.wr_grant, bus.err,
           bus.ram_rden, bus.ram_wren, bus.ram_address, bus.ram_data};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL rstmid outputs: got %h expected 0", got);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if ({bus.rd_valid, bus.rd_busy} !== 2'b00) begin
        errors++;
        $display("FAIL rstmid quiet %0d: valid,busy got %b expected 00",
                 i, {bus.rd_valid, bus.rd_busy});
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.rd_start = 1'b0;
    bus.wr_req   = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_basic("basic", 5);
    test_empty();
    test_back_to_back();
    test_tie();
    test_overflow();
    test_clamp_range();
    test_reset_mid();
    test_basic("recover", 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
